// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES chunk-wide slices.
// Each stage resolves one slice and hands its carry to the next stage. Operands
// are skewed in (unprocessed slices ride forward) and partial sums are de-skewed
// out, so the final stage holds the complete result. A valid/ready handshake
// with full-pipeline stall provides backpressure at one result per cycle.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [CHUNK:0]   part_t;

  // Stage inputs (what stage k sees this cycle).
  word_t a_in   [STAGES];
  word_t b_in   [STAGES];
  word_t sum_in [STAGES];
  logic  c_in   [STAGES];
  logic  v_in   [STAGES];

  // Next-state values produced by each stage.
  part_t part_d  [STAGES];
  word_t a_d     [STAGES];
  word_t b_d     [STAGES];
  word_t sum_d   [STAGES];
  logic  carry_d [STAGES];
  logic  ovf_d;

  // Stage registers. Operands are kept right-aligned: the slice a stage works
  // on is always in the low CHUNK bits of its input.
  word_t a_q     [STAGES];
  word_t b_q     [STAGES];
  word_t sum_q   [STAGES];
  logic  carry_q [STAGES];
  logic  valid_q [STAGES];
  logic  ovf_q;

  logic advance;

  // The whole pipe moves together; it only holds when a result is waiting.
  assign advance  = !valid_q[STAGES-1] || out_ready;
  assign in_ready = advance;

  // Route stage inputs: stage 0 from the ports with subtract folded in,
  // every later stage from the register of the stage before it.
  // NOTE: every signal written here is assigned on every pass, so no latch is inferred.
  always_comb begin
    a_in[0]   = A;
    b_in[0]   = Sub ? ~B : B;
    c_in[0]   = Cin ^ Sub;
    sum_in[0] = '0;
    v_in[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      c_in[k]   = carry_q[k-1];
      sum_in[k] = sum_q[k-1];
      v_in[k]   = valid_q[k-1];
    end
  end

  // Slice adders: add the low slice, shift the operands down by one slice and
  // push the new partial sum in at the top of the de-skew register.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      part_d[k]  = {1'b0, a_in[k][CHUNK-1:0]} + {1'b0, b_in[k][CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, c_in[k]};
      carry_d[k] = part_d[k][CHUNK];
      a_d[k]     = a_in[k] >> CHUNK;
      b_d[k]     = b_in[k] >> CHUNK;
      sum_d[k]   = (sum_in[k] >> CHUNK)
                 | (word_t'(part_d[k][CHUNK-1:0]) << (WIDTH - CHUNK));
    end
    // The last stage works on the top slice: signed overflow is the carry into
    // the MSB (recovered as a^b^sum at the MSB) differing from the carry out.
    ovf_d = part_d[STAGES-1][CHUNK]
          ^ a_in[STAGES-1][CHUNK-1]
          ^ b_in[STAGES-1][CHUNK-1]
          ^ part_d[STAGES-1][CHUNK-1];
  end

  // Pipeline registers: shift every stage forward when the pipe advances.
  // NOTE: these are a handful of flops, not a memory, so all of them are reset;
  // that keeps Sum/Carry/Overflow at zero during reset and drops in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      // NOTE: non-blocking assignments so each stage captures its predecessor's old value.
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= v_in[k];
        carry_q[k] <= carry_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign Sum       = sum_q[STAGES-1];
  assign Carry     = carry_q[STAGES-1];
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: table-driven directed vectors, hand-written stream,
// stall and reset sequences, then randomized traffic against a scoreboard
// whose expectations come from a flat (WIDTH+1)-bit addition.
module tb_pipelined_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             Overflow;

  int errors = 0;
  int checks = 0;
  int n_in   = 0;
  int n_out  = 0;

  res_t exp_q[$];

  logic             obs_in_ready;
  logic             obs_out_valid;
  logic [WIDTH-1:0] obs_sum;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Carry     (Carry),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: flat wide addition with the subtract rules applied directly.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    res_t           r;
    logic [WIDTH-1:0] eb;
    logic [WIDTH:0]   t;
    eb      = sub ? ~b : b;
    t       = {1'b0, a} + {1'b0, eb} + {{WIDTH{1'b0}}, cin ^ sub};
    r.sum   = t[WIDTH-1:0];
    r.carry = t[WIDTH];
    r.ovf   = (a[WIDTH-1] == eb[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  // One clock cycle: observe handshake before the edge, score transfers, advance.
  task automatic do_cycle();
    res_t r;
    #1;
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    obs_sum       = Sum;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        r = exp_q.pop_front();
        check("sb_sum",   64'(Sum),      64'(r.sum));
        check("sb_carry", 64'(Carry),    64'(r.carry));
        check("sb_ovf",   64'(Overflow), 64'(r.ovf));
      end
    end
    if (in_valid && in_ready) begin
      n_in++;
      exp_q.push_back(model(A, B, Cin, Sub));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub, input logic v);
    A        = a;
    B        = b;
    Cin      = cin;
    Sub      = sub;
    in_valid = v;
  endtask

  // Empty the pipe with out_ready high; pending results are scored on the way.
  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4 * STAGES + 8 && exp_q.size() != 0; i++) do_cycle();
    check(name, 64'(exp_q.size()), 64'(0));
    do_cycle();
    do_cycle();
  endtask

  // Single operation through an empty pipe: latency plus table comparison.
  task automatic send_vec(input int idx, input vec_t v);
    int lat;
    drive(v.a, v.b, v.cin, v.sub, 1'b1);
    do_cycle();
    check($sformatf("vec%0d_accept", idx), 64'(obs_in_ready), 64'(1));
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * STAGES) begin
      do_cycle();
      lat++;
    end
    check($sformatf("vec%0d_latency", idx), 64'(lat), 64'(STAGES - 1));
    check($sformatf("vec%0d_sum", idx),   64'(Sum),      64'(v.sum));
    check($sformatf("vec%0d_carry", idx), 64'(Carry),    64'(v.carry));
    check($sformatf("vec%0d_ovf", idx),   64'(Overflow), 64'(v.ovf));
    do_cycle();
  endtask

  vec_t             tbl [7];
  logic [WIDTH-1:0] xa [5];
  logic [WIDTH-1:0] xb [5];
  logic             xc [5];
  logic             xs [5];
  res_t             first_res;
  int               first_c;
  int               cnt_c;
  int               last_c;
  logic [WIDTH-1:0] corner [4];

  initial begin
    tbl[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
    tbl[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000;

    // Reset state.
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum",       64'(Sum),       64'(0));
    check("rst_carry",     64'(Carry),     64'(0));
    check("rst_ovf",       64'(Overflow),  64'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'(1));

    // Directed vectors through an empty pipe.
    for (int i = 0; i < 7; i++) send_vec(i, tbl[i]);
    drain("tbl_drain");

    // Back-to-back stream of 8 with out_ready held high.
    first_c = -1;
    cnt_c   = 0;
    last_c  = -1;
    for (int c = 0; c < 16; c++) begin
      drive(32'(c), 32'(c) << 24, 1'b0, 1'b0, c < 8);
      do_cycle();
      if (c < 8) check($sformatf("stream_in_ready%0d", c), 64'(obs_in_ready), 64'(1));
      if (obs_out_valid) begin
        if (first_c < 0) first_c = c;
        cnt_c++;
        last_c = c;
      end
    end
    check("stream_first_out", 64'(first_c), 64'(STAGES));
    check("stream_count",     64'(cnt_c),   64'(8));
    check("stream_last_out",  64'(last_c),  64'(STAGES + 7));
    drain("stream_drain");

    // Stall with the pipe full: outputs stable, input refused, then drain in order.
    for (int i = 0; i < 5; i++) begin
      xa[i] = $urandom;
      xb[i] = $urandom;
      xc[i] = 1'($urandom);
      xs[i] = 1'($urandom);
    end
    first_res = model(xa[0], xb[0], xc[0], xs[0]);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(xa[i], xb[i], xc[i], xs[i], 1'b1);
      do_cycle();
    end
    drive(xa[4], xb[4], xc[4], xs[4], 1'b1);
    for (int s = 0; s < 5; s++) begin
      do_cycle();
      check($sformatf("stall_in_ready%0d", s),  64'(obs_in_ready),  64'(0));
      check($sformatf("stall_out_valid%0d", s), 64'(obs_out_valid), 64'(1));
      check($sformatf("stall_sum%0d", s),       64'(obs_sum),       64'(first_res.sum));
    end
    check("stall_queue", 64'(exp_q.size()), 64'(4));
    out_ready = 1'b1;
    do_cycle();
    check("release_accept", 64'(obs_in_ready), 64'(1));
    drain("stall_drain");

    // Reset with three operations in flight, the oldest waiting at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, 1'b0, 1'b0, 1'b1);
      do_cycle();
    end
    in_valid = 1'b0;
    do_cycle();
    check("pre_rst_out_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_sum",       64'(Sum),       64'(0));
    check("mid_rst_carry",     64'(Carry),     64'(0));
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send_vec(7, tbl[0]);
    for (int i = 0; i < 2 * STAGES; i++) do_cycle();
    check("post_rst_quiet", 64'(obs_out_valid), 64'(0));

    // Randomized traffic with random backpressure.
    n_in  = 0;
    n_out = 0;
    for (int i = 0; i < 10000; i++) begin
      A         = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      B         = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      Cin       = 1'($urandom);
      Sub       = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      do_cycle();
    end
    drain("rand_drain");
    check("rand_in_out_equal", 64'(n_out), 64'(n_in));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
